multi_channel_pulse_width_detector: RTL and testbench

//  N_CH-channel pulse classifier. Per channel: edge strobes, pulse-length

---
 rtl/multi_channel_pulse_width_detector.sv | 122 ++++++++++++
 tb/tb_multi_channel_pulse_width_detector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_width_detector.sv
// Multi-channel pulse classifier: per-channel edge strobes, run-length measurement,
// window-qualified detect strobe and a saturating hit counter per channel.
module multi_channel_pulse_width_detector #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       pol,
    input  logic [CNT_W-1:0]      min_len,
    input  logic [CNT_W-1:0]      max_len,
    input  logic                  clr_hits,
    output logic [N_CH-1:0]       rise,
    output logic [N_CH-1:0]       fall,
    output logic [N_CH-1:0]       detected,
    output logic [N_CH-1:0]       overlong,
    output logic [N_CH*CNT_W-1:0] pulse_len,
    output logic [N_CH*CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] hit_q [N_CH];
    logic [CNT_W-1:0] hit_d [N_CH];
    logic [N_CH-1:0]  x_s;
    logic [N_CH-1:0]  act_s;
    logic [CNT_W-1:0] lo_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == SAT) begin
            r = SAT;
        end else begin
            r = v + ONE;
        end
        return r;
    endfunction

    assign x_s   = a ^ pol;
    assign act_s = en & {N_CH{rst_n}};

    // Effective lower window bound: a zero-length pulse does not exist.
    always_comb begin
        lo_s = min_len;
        if (min_len == ZERO) begin
            lo_s = ONE;
        end else begin
            lo_s = min_len;
        end
    end

    // Combinational strobes; the run length in cnt_q is the pulse length on the fall cycle.
    always_comb begin
        rise      = {N_CH{1'b0}};
        fall      = {N_CH{1'b0}};
        detected  = {N_CH{1'b0}};
        overlong  = {N_CH{1'b0}};
        pulse_len = {(N_CH*CNT_W){1'b0}};
        hit_cnt   = {(N_CH*CNT_W){1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (act_s[i]) begin
                rise[i] = x_s[i] & (cnt_q[i] == ZERO);
                fall[i] = ~x_s[i] & (cnt_q[i] != ZERO);
            end else begin
                rise[i] = 1'b0;
                fall[i] = 1'b0;
            end
            detected[i] = fall[i] & (cnt_q[i] >= lo_s) & (cnt_q[i] <= max_len);
            overlong[i] = fall[i] & (cnt_q[i] == SAT);
            if (fall[i]) begin
                pulse_len[i*CNT_W +: CNT_W] = cnt_q[i];
            end else begin
                pulse_len[i*CNT_W +: CNT_W] = ZERO;
            end
            hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];
        end
    end

    // Next-state for run counters and hit counters; clear beats a coincident detect.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = ZERO;
            hit_d[i] = hit_q[i];
            if (!en[i]) begin
                cnt_d[i] = ZERO;
            end else if (x_s[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end else begin
                cnt_d[i] = ZERO;
            end
            if (clr_hits) begin
                hit_d[i] = ZERO;
            end else if (detected[i]) begin
                hit_d[i] = sat_inc(hit_q[i]);
            end else begin
                hit_d[i] = hit_q[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= ZERO;
                hit_q[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                hit_q[i] <= hit_d[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Scoreboard bench: a run-length reference model predicts every cycle's outputs,
// a negedge monitor compares them, and directed checks pin the documented scenarios.
module tb_multi_channel_pulse_width_detector;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       a, en, pol;
    logic [CNT_W-1:0]      min_len, max_len;
    logic                  clr_hits;
    logic [N_CH-1:0]       rise, fall, detected, overlong;
    logic [N_CH*CNT_W-1:0] pulse_len, hit_cnt;

    always #5 clk = ~clk;

    multi_channel_pulse_width_detector #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .en(en), .pol(pol),
        .min_len(min_len), .max_len(max_len), .clr_hits(clr_hits),
        .rise(rise), .fall(fall), .detected(detected), .overlong(overlong),
        .pulse_len(pulse_len), .hit_cnt(hit_cnt)
    );

    typedef struct {
        logic [N_CH-1:0]       rise, fall, det, over;
        logic [N_CH*CNT_W-1:0] plen, hit;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   run_len [N_CH];
    int   hits    [N_CH];
    int   hold    [N_CH];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a pulse's length is the number of consecutive active x=1 samples, clipped to SAT.
    function automatic exp_t model_out();
        exp_t e;
        int   lo, len;
        bit   x, act;
        e.rise = '0; e.fall = '0; e.det = '0; e.over = '0; e.plen = '0; e.hit = '0;
        lo = (min_len == 0) ? 1 : int'(min_len);
        for (int i = 0; i < N_CH; i++) begin
            x   = a[i] ^ pol[i];
            act = rst_n && en[i];
            len = (run_len[i] > SAT) ? SAT : run_len[i];
            e.rise[i] = act && x && (run_len[i] == 0);
            e.fall[i] = act && !x && (run_len[i] > 0);
            e.det[i]  = e.fall[i] && (len >= lo) && (len <= int'(max_len));
            e.over[i] = e.fall[i] && (len == SAT);
            e.plen[i*CNT_W +: CNT_W] = e.fall[i] ? len[CNT_W-1:0] : '0;
            e.hit[i*CNT_W +: CNT_W]  = (hits[i] > SAT) ? 4'(SAT) : 4'(hits[i]);
        end
        return e;
    endfunction

    task automatic apply();
        last_e = model_out();
        sb_q.push_back(last_e);
    endtask

    task automatic advance();
        bit x;
        @(posedge clk);
        for (int i = 0; i < N_CH; i++) begin
            x = a[i] ^ pol[i];
            if (!rst_n) begin
                run_len[i] = 0;
                hits[i]    = 0;
            end else begin
                run_len[i] = (en[i] && x) ? ((run_len[i] < 1000) ? run_len[i] + 1 : run_len[i]) : 0;
                hits[i]    = clr_hits ? 0 : hits[i] + (last_e.det[i] ? 1 : 0);
            end
        end
        #1;
    endtask

    task automatic cyc();
        apply();
        advance();
    endtask

    // Monitor: every presented cycle is compared against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_rise",      32'(rise),      32'(e.rise));
            chk("sb_fall",      32'(fall),      32'(e.fall));
            chk("sb_detected",  32'(detected),  32'(e.det));
            chk("sb_overlong",  32'(overlong),  32'(e.over));
            chk("sb_pulse_len", 32'(pulse_len), 32'(e.plen));
            chk("sb_hit_cnt",   32'(hit_cnt),   32'(e.hit));
        end
    end

    initial begin
        logic [15:0] pat, exp_det, exp_rise;
        int widths [4];
        pat      = 16'b1001011011110001;
        exp_det  = 16'b0100100000000000;
        exp_rise = 16'b1001010010000001;
        widths   = '{2, 3, 5, 6};
        for (int i = 0; i < N_CH; i++) begin
            run_len[i] = 0; hits[i] = 0; hold[i] = 0;
        end
        rst_n = 1'b0; a = 4'hF; en = 4'hF; pol = 4'h0;
        min_len = 4'd1; max_len = 4'd1; clr_hits = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state: inputs high yet all strobes held low.
        apply(); #2;
        chk("reset_rise", 32'(rise), 32'h0);
        chk("reset_hit",  32'(hit_cnt), 32'h0);
        advance();
        a = 4'h0; cyc();

        // Compatibility with the one-cycle pulse detector.
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a[0] = pat[15-k];
            apply(); #2;
            chk("t1_rise", 32'(rise[0]), 32'(exp_rise[15-k]));
            chk("t1_det",  32'(detected[0]), 32'(exp_det[15-k]));
            advance();
        end
        a = 4'h0; cyc();

        // Window 3..5 with widths 2, 3, 5, 6.
        clr_hits = 1'b1; cyc(); clr_hits = 1'b0;
        min_len = 4'd3; max_len = 4'd5;
        foreach (widths[w]) begin
            a[0] = 1'b1;
            repeat (widths[w]) cyc();
            a[0] = 1'b0;
            apply(); #2;
            chk("t2_plen", 32'(pulse_len[3:0]), 32'(widths[w]));
            chk("t2_det",  32'(detected[0]), (widths[w] == 3 || widths[w] == 5) ? 32'd1 : 32'd0);
            advance();
            cyc();
        end
        apply(); #2; chk("t2_hits", 32'(hit_cnt[3:0]), 32'd2); advance();

        // Low-pulse polarity.
        rst_n = 1'b0; pol[0] = 1'b1; a[0] = 1'b1; min_len = 4'd2; max_len = 4'd2; cyc();
        rst_n = 1'b1;
        apply(); #2; chk("t3_first_rise", 32'(rise[0]), 32'd0); advance();
        cyc();
        a[0] = 1'b0; cyc(); cyc();
        a[0] = 1'b1;
        apply(); #2;
        chk("t3_fall", 32'(fall[0]), 32'd1);
        chk("t3_det",  32'(detected[0]), 32'd1);
        chk("t3_plen", 32'(pulse_len[3:0]), 32'd2);
        advance();
        pol[0] = 1'b0; a[0] = 1'b0; cyc();

        // Saturation of a 20-cycle pulse, window upper bound 15 then 14.
        min_len = 4'd1;
        for (int m = 15; m >= 14; m--) begin
            max_len = 4'(m);
            a[0] = 1'b1; repeat (20) cyc();
            a[0] = 1'b0;
            apply(); #2;
            chk("t4_plen", 32'(pulse_len[3:0]), 32'd15);
            chk("t4_over", 32'(overlong[0]), 32'd1);
            chk("t4_det",  32'(detected[0]), (m == 15) ? 32'd1 : 32'd0);
            advance();
        end

        // Hit counter saturation and clear-wins.
        clr_hits = 1'b1; cyc(); clr_hits = 1'b0;
        max_len = 4'd1;
        repeat (17) begin
            a[0] = 1'b1; cyc(); a[0] = 1'b0; cyc();
        end
        apply(); #2; chk("t5_hit_sat", 32'(hit_cnt[3:0]), 32'd15); advance();
        a[0] = 1'b1; cyc();
        a[0] = 1'b0; clr_hits = 1'b1;
        apply(); #2; chk("t5_det_clr", 32'(detected[0]), 32'd1); advance();
        clr_hits = 1'b0;
        apply(); #2; chk("t5_hit_clr", 32'(hit_cnt[3:0]), 32'd0); advance();

        // Reset inside a 3-cycle pulse, then enable drop on ch1.
        min_len = 4'd3; max_len = 4'd5;
        a[0] = 1'b1; cyc();
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        apply(); #2; chk("t6_rise_after_rst", 32'(rise[0]), 32'd1); advance();
        a[0] = 1'b0;
        apply(); #2; chk("t6_no_det", 32'(detected[0]), 32'd0); advance();
        a[1:0] = 2'b11; cyc(); cyc();
        en[1] = 1'b0;
        apply(); #2; chk("t6_en_off", 32'({rise[1], fall[1], detected[1]}), 32'd0); advance();
        cyc();
        a[1:0] = 2'b00;
        apply(); #2;
        chk("t6_ch0_det", 32'(detected[0]), 32'd1);
        chk("t6_ch1_quiet", 32'({fall[1], detected[1]}), 32'd0);
        advance();
        en[1] = 1'b1; cyc();

        // Randomized traffic on all channels.
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                end else if ($urandom_range(99) == 0) begin
                    hold[i] = int'($urandom_range(24));
                end else if ($urandom_range(2) == 0) begin
                    a[i] = ~a[i];
                end
                if ($urandom_range(40) == 0) en[i]  = ~en[i];
                if ($urandom_range(80) == 0) pol[i] = ~pol[i];
            end
            if ($urandom_range(15) == 0) begin
                min_len = CNT_W'($urandom_range(5));
                max_len = ($urandom_range(7) == 0) ? 4'd15 : CNT_W'($urandom_range(7));
            end
            clr_hits = ($urandom_range(63) == 0);
            rst_n    = ($urandom_range(199) != 0);
            cyc();
        end
        rst_n = 1'b1; clr_hits = 1'b0; a = 4'h0; cyc(); cyc();
        @(negedge clk); #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
